// File: rtl/corefifo_fwft_pipe.sv
// corefifo_fwft_pipe
// First-word-fall-through output stage for the CoreFIFO read side.
// Reads are issued to the controller/RAM only when the prefetch buffer is
// guaranteed to have room for every word already in flight, so the buffer
// can never overflow. The head word is presented on dout without any user
// read, and a registered copy of it keeps dout stable once the buffer drains.

module corefifo_fwft_pipe #(
  parameter int RWIDTH        = 10,
  parameter int RD_LATENCY    = 1,
  parameter int BUF_DEPTH     = 4,
  parameter int AEMPTY_THRESH = 1,
  parameter bit READ_LOW      = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [RWIDTH-1:0]          fifo_dout,
  input  logic                       rd_en,
  output logic [RWIDTH-1:0]          dout,
  output logic                       dvld,
  output logic                       empty,
  output logic                       aempty,
  output logic [$clog2(BUF_DEPTH):0] count,
  output logic                       underflow
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  // Wide enough to hold count plus every in-flight read without wrapping.
  localparam int SW = CW + 2;

  // Refuse to build configurations that cannot sustain or cannot be sized.
  if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_latency
    $error("corefifo_fwft_pipe: RD_LATENCY must be in 1..4");
  end
  if (BUF_DEPTH < (RD_LATENCY + 1)) begin : g_bad_depth
    $error("corefifo_fwft_pipe: BUF_DEPTH must be at least RD_LATENCY+1");
  end
  if ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_pow2
    $error("corefifo_fwft_pipe: BUF_DEPTH must be a power of 2");
  end

  logic [RD_LATENCY-1:0] infl;
  logic [RWIDTH-1:0]     buf_mem [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [RWIDTH-1:0]     dout_r;
  logic [CW-1:0]         count_r;
  logic                  underflow_r;
  logic                  re_p;
  logic                  pop;
  logic                  arrive;
  logic [SW-1:0]         ninfl;
  logic [SW-1:0]         occupancy;

  assign re_p       = READ_LOW ? ~rd_en : rd_en;
  assign pop        = re_p && (count_r != '0);
  assign arrive     = infl[RD_LATENCY-1];
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  // Count reads that have been issued but whose data is not yet in the buffer.
  always_comb begin
    ninfl = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      ninfl = ninfl + SW'(infl[i]);
    end
    occupancy = SW'(count_r) + ninfl;
  end

  // Issue a read only if the word, once it lands, is certain to have a slot;
  // a pop this cycle frees one. Aempty looks at buffered plus in-flight words.
  always_comb begin
    fifo_rd_en = 1'b0;
    aempty     = 1'b1;
    if (!reset) begin
      fifo_rd_en = !fifo_empty && ((occupancy - SW'(pop)) < SW'(BUF_DEPTH));
      aempty     = (occupancy <= SW'(AEMPTY_THRESH)) && fifo_empty;
    end
  end

  // Track each issued read through the RAM latency; the top bit marks arrival.
  always_ff @(posedge clk) begin
    if (reset) begin
      infl <= '0;
    end else begin
      infl[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        infl[i] <= infl[i-1];
      end
    end
  end

  // Prefetch storage: arriving RAM data is captured at the write pointer.
  always_ff @(posedge clk) begin
    if (!reset && arrive) begin
      buf_mem[wr_ptr] <= fifo_dout;
    end
  end

  // Circular pointers and occupancy; arrival and pop together leave count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (arrive) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({arrive, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered head word: loads the next buffered or arriving word, and holds
  // the last popped word while the buffer is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r <= '0;
    end else if (count_r == '0) begin
      if (arrive) begin
        dout_r <= fifo_dout;
      end
    end else if (pop) begin
      if (count_r >= CW'(2)) begin
        dout_r <= buf_mem[rd_ptr_nxt];
      end else if (arrive) begin
        dout_r <= fifo_dout;
      end
    end
  end

  // Sticky record of any pop attempted while nothing was visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_r <= 1'b0;
    end else if (re_p && (count_r == '0)) begin
      underflow_r <= 1'b1;
    end
  end

  assign dout      = dout_r;
  assign count     = count_r;
  assign dvld      = (count_r != '0);
  assign empty     = (count_r == '0);
  assign underflow = underflow_r;

endmodule

// File: tb/tb_corefifo_fwft_pipe.sv
// tb_corefifo_fwft_pipe
// Drives two instances (latency 2 / depth 4 active-high, and latency 4 /
// depth 8 active-low) from one controller+RAM model. A timestamped
// scoreboard of issued words predicts every output of the selected instance.

module tb_corefifo_fwft_pipe;

  typedef struct {
    logic [7:0] w;
    int         vis;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic       pop_user;
  logic       rd_en_a, rd_en_b;
  logic [7:0] ram_pipe [4];
  logic       issue_l;
  logic [7:0] word_l;

  logic       fifo_rd_en_a, fifo_rd_en_b;
  logic [7:0] dout_a, dout_b;
  logic       dvld_a, dvld_b, empty_a, empty_b, aempty_a, aempty_b;
  logic       underflow_a, underflow_b;
  logic [2:0] count_a;
  logic [3:0] count_b;

  sb_t        sb_q [$];
  int         cyc, avail, gen_idx, mode, lat, depth, thresh;
  logic [7:0] last_word;
  bit         uf_exp, checking_on;
  int         assert_cnt, fail_cnt;

  bit         obs_rd, obs_dvld, obs_empty, obs_aempty, obs_uf;
  logic [7:0] obs_dout;
  int         obs_cnt;

  int         first_rd, first_v, dv_cnt, max_cnt;
  bit         seen;

  // Free-running clock.
  always #5 clk = ~clk;

  assign rd_en_a = pop_user;
  assign rd_en_b = ~pop_user;

  corefifo_fwft_pipe #(
    .RWIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(4), .AEMPTY_THRESH(1), .READ_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_a),
    .fifo_dout(ram_pipe[1]), .rd_en(rd_en_a), .dout(dout_a), .dvld(dvld_a),
    .empty(empty_a), .aempty(aempty_a), .count(count_a), .underflow(underflow_a)
  );

  corefifo_fwft_pipe #(
    .RWIDTH(8), .RD_LATENCY(4), .BUF_DEPTH(8), .AEMPTY_THRESH(1), .READ_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_b),
    .fifo_dout(ram_pipe[3]), .rd_en(rd_en_b), .dout(dout_b), .dvld(dvld_b),
    .empty(empty_b), .aempty(aempty_b), .count(count_b), .underflow(underflow_b)
  );

  // RAM read port model: data for a read issued in cycle t is on pipe[L-1] in cycle t+L.
  always @(posedge clk) begin
    ram_pipe[0] <= issue_l ? word_l : 8'hEE;
    for (int i = 1; i < 4; i++) begin
      ram_pipe[i] <= ram_pipe[i-1];
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    assert_cnt++;
    if (obs != exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d, mode %0d)",
               tag, obs, exp, cyc, mode);
    end
  endtask

  // One clock cycle: drive inputs, predict and compare outputs, advance the model.
  task automatic applyStimulus(input bit rst, input bit force_empty, input bit pop);
    int         vcount;
    bit         valid, pop_ok, exp_rd, exp_ae;
    logic [7:0] exp_dout, word;
    sb_t        e;
    reset      = rst;
    pop_user   = pop;
    fifo_empty = force_empty || (avail == 0);
    #1;
    if (mode == 0) begin
      obs_rd = fifo_rd_en_a; obs_dvld = dvld_a; obs_empty = empty_a;
      obs_aempty = aempty_a; obs_uf = underflow_a; obs_dout = dout_a; obs_cnt = int'(count_a);
    end else begin
      obs_rd = fifo_rd_en_b; obs_dvld = dvld_b; obs_empty = empty_b;
      obs_aempty = aempty_b; obs_uf = underflow_b; obs_dout = dout_b; obs_cnt = int'(count_b);
    end
    vcount = 0;
    foreach (sb_q[i]) if (sb_q[i].vis <= cyc) vcount++;
    valid    = (vcount != 0);
    pop_ok   = pop && valid;
    exp_rd   = !rst && !fifo_empty && ((sb_q.size() - int'(pop_ok)) < depth);
    exp_ae   = rst || ((sb_q.size() <= thresh) && fifo_empty);
    exp_dout = valid ? sb_q[0].w : last_word;
    if (checking_on) begin
      checkOutput("count",      obs_cnt,          vcount);
      checkOutput("dvld",       int'(obs_dvld),   int'(valid));
      checkOutput("empty",      int'(obs_empty),  int'(!valid));
      checkOutput("dout",       int'(obs_dout),   int'(exp_dout));
      checkOutput("underflow",  int'(obs_uf),     int'(uf_exp));
      checkOutput("fifo_rd_en", int'(obs_rd),     int'(exp_rd));
      checkOutput("aempty",     int'(obs_aempty), int'(exp_ae));
    end
    word    = 8'((gen_idx + 1) * 17);
    issue_l = obs_rd;
    word_l  = word;
    if (rst) begin
      sb_q.delete();
      uf_exp      = 1'b0;
      last_word   = 8'h00;
      checking_on = 1'b1;
    end else begin
      if (pop_ok) begin
        last_word = sb_q[0].w;
        void'(sb_q.pop_front());
      end else if (pop) begin
        uf_exp = 1'b1;
      end
      if (obs_rd) begin
        e.w   = word;
        e.vis = cyc + lat + 1;
        sb_q.push_back(e);
        gen_idx++;
        if (avail > 0) avail--;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Directed scenarios followed by a long randomised run.
  initial begin
    reset = 1'b1; fifo_empty = 1'b1; pop_user = 1'b0; issue_l = 1'b0; word_l = 8'h00;
    mode = 0; lat = 2; depth = 4; thresh = 1; avail = 0; gen_idx = 0; cyc = 0;
    last_word = 8'h00; uf_exp = 1'b0; checking_on = 1'b0; assert_cnt = 0; fail_cnt = 0;
    @(negedge clk);

    // Reset state.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rst_dout", int'(obs_dout), 0);
    checkOutput("rst_aempty", int'(obs_aempty), 1);

    // Fill after reset: first word at cycle 3, reads stop at four words.
    gen_idx = 0; avail = 1000;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (k == 0) checkOutput("t1_rd_c0", int'(obs_rd), 1);
      if (k == 2) checkOutput("t1_dvld_c2", int'(obs_dvld), 0);
      if (k == 3) begin
        checkOutput("t1_dout_c3", int'(obs_dout), 8'h11);
        checkOutput("t1_dvld_c3", int'(obs_dvld), 1);
      end
      if (k == 6) begin
        checkOutput("t1_count_full", obs_cnt, 4);
        checkOutput("t1_rd_stop", int'(obs_rd), 0);
      end
    end

    // Continuous popping with a never-empty controller.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k >= 4) begin
        checkOutput("t2_count_steady", obs_cnt, 2);
        checkOutput("t2_rd_steady", int'(obs_rd), 1);
      end
    end

    // Two-word drain, almost-empty, then underflow.
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
    gen_idx = 0; avail = 2;
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_count2", obs_cnt, 2);
    checkOutput("t3_aempty_at2", int'(obs_aempty), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_aempty_at1", int'(obs_aempty), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_empty", int'(obs_empty), 1);
    checkOutput("t3_hold_dout", int'(obs_dout), 8'h22);
    checkOutput("t3_no_uf_yet", int'(obs_uf), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t3_uf_sticky", int'(obs_uf), 1);
    end

    // Reset with reads in flight: late data must be dropped.
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
    gen_idx = 0; avail = 1000;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    avail = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t4_flushed", obs_cnt, 0);
    end
    avail = 3; seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (obs_dvld && !seen) begin
        seen = 1'b1;
        checkOutput("t4_first_word", int'(obs_dout), 8'h55);
      end
    end
    checkOutput("t4_word_seen", int'(seen), 1);

    // Latency 4, depth 8, active-low read held asserted.
    mode = 1; lat = 4; depth = 8; checking_on = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    gen_idx = 0; avail = 1000; first_rd = -1; first_v = -1; dv_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (obs_rd && (first_rd < 0)) first_rd = k;
      if (obs_dvld && (first_v < 0)) first_v = k;
      if ((k >= 20) && obs_dvld) dv_cnt++;
    end
    checkOutput("t5_latency", first_v - first_rd, 5);
    checkOutput("t5_throughput", dv_cnt, 20);

    // Random pops against a random controller empty pattern.
    mode = 0; lat = 2; depth = 4; checking_on = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    gen_idx = 0; avail = 1000000; max_cnt = 0;
    for (int k = 0; k < 10000; k++) begin
      applyStimulus(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if (obs_cnt > max_cnt) max_cnt = obs_cnt;
    end
    checkOutput("t6_max_count", int'(max_cnt <= 4), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
